axi_lite_ram: RTL and testbench
===============================

Name: axi_lite_ram

Overview:
- AXI4-Lite slave, single-port-per-direction word memory.
- Consumes the DMA engine's master read/write ports. The DMA control bus is unchanged; only the DMA m_axi_* ports connect here.
- Provides backing store for DMA source/destination buffers and for host writes relayed through the DMA.
- One independent read channel and one write channel; one outstanding transaction per channel.

Parameters:
- ADDR_WIDTH, 32, byte-address width of AW/AR.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH_WORDS.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_axi_awready  out  1  write-address ready.
- s_axi_awvalid  in  1  write-address valid.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_wready  out  1  write-data ready.
- s_axi_wvalid  in  1  write-data valid.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wdata  in  32  write data.
- s_axi_bready  in  1  response ready.
- s_axi_bvalid  out  1  response valid.
- s_axi_bresp  out  2  write response.
- s_axi_arready  out  1  read-address ready.
- s_axi_arvalid  in  1  read-address valid.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_rready  in  1  read-data ready.
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.

Behaviour:
- Reset (async assert, sync release):
  - aw_held, w_held, bvalid and rvalid are 0.
  - awready and wready are 1. arready is 1.
  - bresp, rresp and rdata are 0.
  - Memory contents are not reset.
  - Reset mid-transaction drops all in-flight AW/W/AR and responses silently.
- Decode:
  - in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH_WORDS).
  - Word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - addr[1:0] is ignored.
- Write channel:
  - awready = !aw_held; wready = !w_held. Each channel is latched independently on its handshake. AW and W may arrive in either order or in the same cycle.
  - Commit when aw_held && w_held && !bvalid:
    - If in range, write the bytes selected by wstrb at that edge.
    - Clear both held flags and set bvalid.
    - bresp = OKAY (2'b00) in range, SLVERR (2'b10) out of range. An out-of-range write leaves memory unchanged.
  - Latency: with AW and W both handshaken at edge N, memory is written and bvalid rises at edge N+1.
  - bvalid holds with stable bresp until bready; clears on the bvalid&&bready edge.
  - A new commit can occur in the cycle after bvalid clears. The held flags allow the next AW/W to be accepted while B is pending.
  - wstrb == 0: commits with OKAY, no bytes change.
- Read channel:
  - arready = !rvalid || rready, giving one read per cycle at full throughput.
  - AR handshake at edge N: rvalid=1 and rdata valid after edge N (1-cycle latency).
  - rresp = OKAY in range. Out of range: rresp = SLVERR and rdata = 0.
  - rdata/rresp held stable while rvalid && !rready.
- Read/write collision: read and write to the same word at the same edge is read-first; the read returns the old data.
- Read and write channels are fully independent; no ordering between them is guaranteed.

Optional Feature:
- Macro: AXI_LITE_RAM_PARITY_EN.
- Defined:
  - Memory stores 1 even-parity bit per byte (36-bit words).
  - Parity is written alongside each enabled byte.
  - On read, any byte parity mismatch yields rresp = SLVERR with the raw rdata still returned.
  - Adds input port err_inject (1 bit): when high during a commit, it inverts the stored parity of byte 0.
- Undefined:
  - No parity storage and no err_inject port.
  - rresp depends only on range.

Decomposition:
- Package axi_pkg:
  - typedef enum logic [1:0] resp_t {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
  - Constant AXI_DATA_W = 32 and AXI_STRB_W = 4.
- Sub-module sram_1r1w:
  - Parameters WIDTH and DEPTH; byte-write-enable sync write.
  - Registered sync read with read enable; read-first on collision.
  - Inferable as block RAM.
- Top module holds the handshake/commit logic and address decode.

Test Plan:
- AW 0x10 and W 0xDEADBEEF (wstrb 4'hF) in the same cycle, bready=1 -> bvalid at +1 cycle with OKAY. AR 0x10 -> rvalid at +1 cycle, rdata 0xDEADBEEF, OKAY.
- W (0x000000AA, wstrb 4'h1) two cycles before AW 0x20, over prior word 0x11223344 -> one B with OKAY; readback 0x112233AA.
- bready held low 5 cycles after a write -> bvalid and bresp stable. A second AW/W pair is accepted but not committed until B completes. Exactly one B per write.
- Back-to-back AR 0x0, 0x4, 0x8 with rready=1 -> arready stays 1; three consecutive rvalid beats in address order.
- AR and W commit to 0x30 on the same edge (old 0x1, new 0x2) -> rdata 0x1; a later read returns 0x2.
- Write and read at BASE_ADDR+4*DEPTH_WORDS -> bresp SLVERR, rresp SLVERR, rdata 0, memory unchanged. With AXI_LITE_RAM_PARITY_EN: err_inject during a write -> rresp SLVERR. Assert reset mid-B -> bvalid=0 immediately.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response encoding, bus widths and byte parity helper
// used by the axi_lite_ram slice.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    // Even parity: the stored bit makes each 9-bit lane carry an even count of ones.
    function automatic logic byte_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port RAM: one byte-lane-enabled synchronous write port and one
// registered read port with read enable; read-first on same-address collision.
module sram_1r1w #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [LANES-1:0]         be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    localparam int LANE_W = WIDTH / LANES;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Lane-masked write; left unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem_r[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read; sampling the old array contents makes collisions read-first.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite word RAM slave: independent AW/W holding, write commit, 1-cycle read.
// Define AXI_LITE_RAM_PARITY_EN for per-byte parity storage and the err_inject port.
module axi_lite_ram
    import axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef AXI_LITE_RAM_PARITY_EN
    input  logic                  err_inject,
`endif
    output logic                  s_axi_awready,
    input  logic                  s_axi_awvalid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    output logic                  s_axi_wready,
    input  logic                  s_axi_wvalid,
    input  logic [3:0]            s_axi_wstrb,
    input  logic [31:0]           s_axi_wdata,
    input  logic                  s_axi_bready,
    output logic                  s_axi_bvalid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_arready,
    input  logic                  s_axi_arvalid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_rready,
    output logic                  s_axi_rvalid,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef AXI_LITE_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int MEM_W = LANE_W * AXI_STRB_W;
    // One extra bit so a window ending at the top of the address space does not wrap.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(32'd4 * DEPTH_WORDS);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < LIMIT_EXT);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 32'd2);
    endfunction

    logic                  aw_held_r;
    logic                  w_held_r;
    logic [ADDR_WIDTH-1:0] aw_addr_r;
    logic [AXI_DATA_W-1:0] w_data_r;
    logic [AXI_STRB_W-1:0] w_strb_r;
    logic                  bvalid_r;
    resp_t                 bresp_r;
    logic                  rvalid_r;
    logic                  rd_hit_r;
    logic                  rd_miss_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
    logic                  wr_in_range_s;
    logic                  arready_s;
    logic                  ar_hs_s;
    logic [MEM_W-1:0]      mem_wdata_s;
    logic [MEM_W-1:0]      mem_rdata_s;
    logic [AXI_DATA_W-1:0] rd_data_s;
    logic                  par_err_s;

    // Channel handshakes and the write commit condition.
    always_comb begin
        aw_hs_s       = s_axi_awvalid && !aw_held_r;
        w_hs_s        = s_axi_wvalid && !w_held_r;
        commit_s      = aw_held_r && w_held_r && !bvalid_r;
        wr_in_range_s = in_range(aw_addr_r);
        arready_s     = !rvalid_r || s_axi_rready;
        ar_hs_s       = s_axi_arvalid && arready_s;
    end

    // AW/W holding registers and the B response; held flags free up at commit,
    // so the next pair can be accepted while B is still waiting for bready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_addr_r <= {ADDR_WIDTH{1'b0}};
            w_data_r  <= {AXI_DATA_W{1'b0}};
            w_strb_r  <= {AXI_STRB_W{1'b0}};
            bvalid_r  <= 1'b0;
            bresp_r   <= OKAY;
        end else begin
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= wr_in_range_s ? OKAY : SLVERR;
            end else begin
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    aw_addr_r <= s_axi_awaddr;
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    w_data_r <= s_axi_wdata;
                    w_strb_r <= s_axi_wstrb;
                end
                if (bvalid_r && s_axi_bready) begin
                    bvalid_r <= 1'b0;
                end
            end
        end
    end

    // Place each data byte in its memory lane, with its parity bit above it when enabled.
    always_comb begin
        mem_wdata_s = {MEM_W{1'b0}};
        for (int i = 0; i < AXI_STRB_W; i++) begin
            mem_wdata_s[i*LANE_W +: 8] = w_data_r[i*8 +: 8];
`ifdef AXI_LITE_RAM_PARITY_EN
            mem_wdata_s[i*LANE_W + 8] = byte_parity(w_data_r[i*8 +: 8]);
`endif
        end
`ifdef AXI_LITE_RAM_PARITY_EN
        mem_wdata_s[8] = mem_wdata_s[8] ^ err_inject;
`endif
    end

    // Strip lanes back to bytes and flag any lane whose stored parity disagrees.
    always_comb begin
        rd_data_s = {AXI_DATA_W{1'b0}};
        par_err_s = 1'b0;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            rd_data_s[i*8 +: 8] = mem_rdata_s[i*LANE_W +: 8];
`ifdef AXI_LITE_RAM_PARITY_EN
            par_err_s = par_err_s |
                        (mem_rdata_s[i*LANE_W + 8] ^ byte_parity(mem_rdata_s[i*LANE_W +: 8]));
`endif
        end
    end

    sram_1r1w #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH_WORDS),
        .LANES (AXI_STRB_W)
    ) u_sram (
        .clk   (clk),
        .we    (commit_s && wr_in_range_s),
        .be    (w_strb_r),
        .waddr (word_index(aw_addr_r)),
        .wdata (mem_wdata_s),
        .re    (ar_hs_s),
        .raddr (word_index(s_axi_araddr)),
        .rdata (mem_rdata_s)
    );

    // Read response state; the data itself is the RAM output register, masked on a miss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_r  <= 1'b0;
            rd_hit_r  <= 1'b0;
            rd_miss_r <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                rvalid_r  <= 1'b1;
                rd_hit_r  <= in_range(s_axi_araddr);
                rd_miss_r <= !in_range(s_axi_araddr);
            end else if (s_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign s_axi_awready = !aw_held_r;
    assign s_axi_wready  = !w_held_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_s;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rd_hit_r ? rd_data_s : 32'h0000_0000;
    assign s_axi_rresp   = (rd_miss_r || (rd_hit_r && par_err_s)) ? SLVERR : OKAY;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed self-checking bench for axi_lite_ram: vector table plus hand-written
// multi-cycle sequences (W-before-AW, B stall, read burst, collision, reset).
`timescale 1ns/1ps
module tb_axi_lite_ram;

    logic        clk;
    logic        reset;
`ifdef AXI_LITE_RAM_PARITY_EN
    logic        err_inject;
`endif
    logic        s_axi_awready;
    logic        s_axi_awvalid;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_wready;
    logic        s_axi_wvalid;
    logic [3:0]  s_axi_wstrb;
    logic [31:0] s_axi_wdata;
    logic        s_axi_bready;
    logic        s_axi_bvalid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arready;
    logic        s_axi_arvalid;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rready;
    logic        s_axi_rvalid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    int checks = 0;
    int errors = 0;

    axi_lite_ram dut (
        .clk           (clk),
        .reset         (reset),
`ifdef AXI_LITE_RAM_PARITY_EN
        .err_inject    (err_inject),
`endif
        .s_axi_awready (s_axi_awready),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arready (s_axi_arready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int lat);
        logic aw_hs;
        logic w_hs;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = addr;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_bready  = 1'b1;
        for (int n = 0; n < 20 && (s_axi_awvalid || s_axi_wvalid); n++) begin
            #1;
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick();
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs) s_axi_wvalid = 1'b0;
        end
        if (s_axi_awvalid || s_axi_wvalid) begin
            checks++;
            errors++;
            $display("FAIL wr_handshake_timeout: addr %h not accepted", addr);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end
        lat = 0;
        while (!s_axi_bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp = s_axi_bresp;
        tick();
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_rready  = 1'b1;
        #1;
        for (int n = 0; n < 20 && !s_axi_arready; n++) begin
            tick();
        end
        tick();
        s_axi_arvalid = 1'b0;
        lat = 0;
        while (!s_axi_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        data = s_axi_rdata;
        resp = s_axi_rresp;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat;

        reset         = 1'b1;
        s_axi_awvalid = 1'b0;
        s_axi_awaddr  = 32'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_wdata   = 32'h0;
        s_axi_wstrb   = 4'h0;
        s_axi_bready  = 1'b1;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = 32'h0;
        s_axi_rready  = 1'b1;
`ifdef AXI_LITE_RAM_PARITY_EN
        err_inject    = 1'b0;
`endif

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 2'b00, 32'h1122_3344});
        vecs.push_back('{1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0042, 32'h0000_7700, 4'h2, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0043, 32'h0,         4'h0, 2'b00, 32'hA5A5_77A5});
        vecs.push_back('{1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0044, 32'h0,         4'h0, 2'b00, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h0101_0101, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D});
        vecs.push_back('{1'b1, 32'h0000_1000, 32'h0BAD_BAD0, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0101_0101});
        vecs.push_back('{1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 4'hF, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D});

        // Reset state
        tick();
        tick();
        check("rst_awready", 32'(s_axi_awready), 32'd1);
        check("rst_wready",  32'(s_axi_wready),  32'd1);
        check("rst_arready", 32'(s_axi_arready), 32'd1);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_bresp",   32'(s_axi_bresp),   32'd0);
        check("rst_rresp",   32'(s_axi_rresp),   32'd0);
        check("rst_rdata",   s_axi_rdata,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs, lat);
                check($sformatf("vec%0d_bresp", i), 32'(rs), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_blat", i), 32'(lat), 32'd1);
            end else begin
                axi_read(vecs[i].addr, rd, rs, lat);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_rlat", i), 32'(lat), 32'd0);
            end
        end

        // W two cycles ahead of AW, partial strobe over 0x11223344
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = 32'h0000_00AA;
        s_axi_wstrb  = 4'h1;
        #1;
        check("seqA_wready", 32'(s_axi_wready), 32'd1);
        tick();
        s_axi_wvalid = 1'b0;
        check("seqA_wready_held", 32'(s_axi_wready), 32'd0);
        tick();
        check("seqA_no_early_b", 32'(s_axi_bvalid), 32'd0);
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h0000_0020;
        tick();
        s_axi_awvalid = 1'b0;
        check("seqA_b_not_yet", 32'(s_axi_bvalid), 32'd0);
        tick();
        check("seqA_bvalid", 32'(s_axi_bvalid), 32'd1);
        check("seqA_bresp",  32'(s_axi_bresp),  32'd0);
        tick();
        check("seqA_b_done", 32'(s_axi_bvalid), 32'd0);
        tick();
        check("seqA_single_b", 32'(s_axi_bvalid), 32'd0);
        axi_read(32'h0000_0020, rd, rs, lat);
        check("seqA_readback", rd, 32'h1122_33AA);

        // B stalled by bready low; second pair accepted but held until B completes
        s_axi_bready  = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h0000_0050;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0000_0055;
        s_axi_wstrb   = 4'hF;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        tick();
        check("seqB_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h0000_0054;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0000_0066;
        #1;
        check("seqB_awready_during_b", 32'(s_axi_awready), 32'd1);
        check("seqB_wready_during_b",  32'(s_axi_wready),  32'd1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("seqB_stall%0d_bvalid", k), 32'(s_axi_bvalid), 32'd1);
            check($sformatf("seqB_stall%0d_bresp", k),  32'(s_axi_bresp),  32'd0);
            check($sformatf("seqB_stall%0d_awheld", k), 32'(s_axi_awready), 32'd0);
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        check("seqB_first_b_done", 32'(s_axi_bvalid), 32'd0);
        tick();
        check("seqB_second_b", 32'(s_axi_bvalid), 32'd1);
        check("seqB_second_bresp", 32'(s_axi_bresp), 32'd0);
        tick();
        check("seqB_second_b_done", 32'(s_axi_bvalid), 32'd0);
        tick();
        check("seqB_no_extra_b", 32'(s_axi_bvalid), 32'd0);
        axi_read(32'h0000_0050, rd, rs, lat);
        check("seqB_read50", rd, 32'h0000_0055);
        axi_read(32'h0000_0054, rd, rs, lat);
        check("seqB_read54", rd, 32'h0000_0066);

        // Back-to-back reads at full throughput
        axi_write(32'h0000_0000, 32'h0000_00A0, 4'hF, rs, lat);
        axi_write(32'h0000_0004, 32'h0000_00A4, 4'hF, rs, lat);
        axi_write(32'h0000_0008, 32'h0000_00A8, 4'hF, rs, lat);
        s_axi_rready  = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 32'h0000_0000;
        #1;
        check("seqC_arready0", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_araddr = 32'h0000_0004;
        #1;
        check("seqC_rvalid0",  32'(s_axi_rvalid),  32'd1);
        check("seqC_rdata0",   s_axi_rdata,        32'h0000_00A0);
        check("seqC_arready1", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_araddr = 32'h0000_0008;
        #1;
        check("seqC_rvalid1",  32'(s_axi_rvalid),  32'd1);
        check("seqC_rdata1",   s_axi_rdata,        32'h0000_00A4);
        check("seqC_arready2", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        check("seqC_rvalid2", 32'(s_axi_rvalid), 32'd1);
        check("seqC_rdata2",  s_axi_rdata,       32'h0000_00A8);
        tick();
        check("seqC_idle", 32'(s_axi_rvalid), 32'd0);

        // Read and write commit to the same word on the same edge: read-first
        axi_write(32'h0000_0030, 32'h0000_0001, 4'hF, rs, lat);
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h0000_0030;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0000_0002;
        s_axi_wstrb   = 4'hF;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 32'h0000_0030;
        tick();
        s_axi_arvalid = 1'b0;
        check("seqD_bvalid", 32'(s_axi_bvalid), 32'd1);
        check("seqD_rvalid", 32'(s_axi_rvalid), 32'd1);
        check("seqD_old_data", s_axi_rdata, 32'h0000_0001);
        tick();
        axi_read(32'h0000_0030, rd, rs, lat);
        check("seqD_new_data", rd, 32'h0000_0002);

`ifdef AXI_LITE_RAM_PARITY_EN
        // Corrupted byte-0 parity surfaces as SLVERR with raw data
        err_inject = 1'b1;
        axi_write(32'h0000_0070, 32'h0F0F_0F0F, 4'hF, rs, lat);
        err_inject = 1'b0;
        check("par_inject_bresp", 32'(rs), 32'd0);
        axi_read(32'h0000_0070, rd, rs, lat);
        check("par_inject_rresp", 32'(rs), 32'd2);
        check("par_inject_rdata", rd, 32'h0F0F_0F0F);
        axi_write(32'h0000_0070, 32'h0F0F_0F0F, 4'hF, rs, lat);
        axi_read(32'h0000_0070, rd, rs, lat);
        check("par_clean_rresp", 32'(rs), 32'd0);
`endif

        // Reset while B and R are both pending
        s_axi_bready  = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'h0000_0060;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0000_0099;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 32'h0000_0010;
        tick();
        s_axi_arvalid = 1'b0;
        check("seqE_bvalid_pre", 32'(s_axi_bvalid), 32'd1);
        check("seqE_rvalid_pre", 32'(s_axi_rvalid), 32'd1);
        check("seqE_rdata_pre",  s_axi_rdata,       32'hDEAD_BEEF);
        #2;
        reset = 1'b1;
        #1;
        check("seqE_bvalid_rst",  32'(s_axi_bvalid),  32'd0);
        check("seqE_rvalid_rst",  32'(s_axi_rvalid),  32'd0);
        check("seqE_rdata_rst",   s_axi_rdata,        32'd0);
        check("seqE_awready_rst", 32'(s_axi_awready), 32'd1);
        check("seqE_wready_rst",  32'(s_axi_wready),  32'd1);
        @(negedge clk);
        reset        = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        tick();
        tick();
        check("seqE_no_b_after_rst", 32'(s_axi_bvalid), 32'd0);
        axi_read(32'h0000_0010, rd, rs, lat);
        check("seqE_mem_kept", rd, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
